// File: rtl/mips_io_responder.sv
// Memory-mapped I/O slave for the multicycle MIPS: button ready flags, switch input,
// LED register and an 8-digit multiplexed 7-segment display.

module mips_io_debounce #(
   parameter int DEBOUNCE_CYC = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);
   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          expire;

   assign differ = sync[1] ^ level;
   assign expire = differ && (cnt == CNT_MAX);
   // The press fires in the cycle whose edge accepts the new high level.
   assign press  = expire && sync[1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync  <= 2'b00;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync <= {sync[0], raw};
         if (!differ) begin
            cnt <= '0;
         end else if (expire) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module mips_io_responder #(
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int SCAN_BITS    = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pread,
   input  logic        pwrite,
   input  logic [7:0]  addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        btnl,
   input  logic        btnr,
   input  logic [15:0] sw,
   output logic [11:0] led,
   output logic [7:0]  an,
   output logic [6:0]  a2g
);
   typedef enum logic [1:0] {
      REG_STATUS = 2'd0,
      REG_SWITCH = 2'd1,
      REG_LED    = 2'd2,
      REG_DISP   = 2'd3
   } reg_sel_t;

   reg_sel_t              sel;
   logic                  press_l;
   logic                  press_r;
   logic                  sw_rdy;
   logic                  led_rdy;
   logic [15:0]           sw_m;
   logic [15:0]           sw_s;
   logic [31:0]           disp;
   logic [SCAN_BITS-1:0]  scan_cnt;
   logic [2:0]            digit;
   logic [3:0]            nibble;
   logic                  unused_addr;

   assign sel         = reg_sel_t'(addr[3:2]);
   assign unused_addr = ^{addr[7:4], addr[1:0]};

   mips_io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_l (
      .clk   (clk),
      .reset (reset),
      .raw   (btnl),
      .press (press_l)
   );

   mips_io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_r (
      .clk   (clk),
      .reset (reset),
      .raw   (btnr),
      .press (press_r)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_m     <= '0;
         sw_s     <= '0;
         sw_rdy   <= 1'b0;
         led_rdy  <= 1'b0;
         led      <= '0;
         disp     <= '0;
         scan_cnt <= '0;
      end else begin
         sw_m     <= sw;
         sw_s     <= sw_m;
         scan_cnt <= scan_cnt + 1'b1;

         // A press coinciding with the clearing access wins, so no event is lost.
         if (press_r)
            sw_rdy <= 1'b1;
         else if (pread && sel == REG_SWITCH)
            sw_rdy <= 1'b0;

         if (press_l)
            led_rdy <= 1'b1;
         else if (pwrite && sel == REG_LED)
            led_rdy <= 1'b0;

         if (pwrite && sel == REG_LED)
            led <= writedata[11:0];
         if (pwrite && sel == REG_DISP)
            disp <= writedata;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      readdata = 32'b0;
      case (sel)
         REG_STATUS: readdata = {30'b0, led_rdy, sw_rdy};
         REG_SWITCH: readdata = {16'b0, sw_s};
         default:    readdata = 32'b0;
      endcase
   end

   assign digit  = scan_cnt[SCAN_BITS-1 -: 3];
   assign an     = ~(8'b1 << digit);
   assign nibble = disp[{digit, 2'b00} +: 4];

   // Segment order is {a,b,c,d,e,f,g}, a in the MSB, lit segments driven low.
   always_comb begin
      a2g = 7'b1111111;
      case (nibble)
         4'h0: a2g = 7'b0000001;
         4'h1: a2g = 7'b1001111;
         4'h2: a2g = 7'b0010010;
         4'h3: a2g = 7'b0000110;
         4'h4: a2g = 7'b1001100;
         4'h5: a2g = 7'b0100100;
         4'h6: a2g = 7'b0100000;
         4'h7: a2g = 7'b0001111;
         4'h8: a2g = 7'b0000000;
         4'h9: a2g = 7'b0000100;
         4'ha: a2g = 7'b0001000;
         4'hb: a2g = 7'b1100000;
         4'hc: a2g = 7'b0110001;
         4'hd: a2g = 7'b1000010;
         4'he: a2g = 7'b0110000;
         default: a2g = 7'b0111000;
      endcase
   end
endmodule

// File: tb/tb_mips_io_responder.sv
// Directed self-checking bench for mips_io_responder with DEBOUNCE_CYC=4, SCAN_BITS=3.

module tb_mips_io_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pread = 1'b0;
   logic        pwrite = 1'b0;
   logic [7:0]  addr = 8'h00;
   logic [31:0] writedata = 32'h0;
   logic [31:0] readdata;
   logic        btnl = 1'b0;
   logic        btnr = 1'b0;
   logic [15:0] sw = 16'h0;
   logic [11:0] led;
   logic [7:0]  an;
   logic [6:0]  a2g;

   int passed = 0;
   int total  = 0;

   mips_io_responder #(.DEBOUNCE_CYC(4), .SCAN_BITS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .pread     (pread),
      .pwrite    (pwrite),
      .addr      (addr),
      .writedata (writedata),
      .readdata  (readdata),
      .btnl      (btnl),
      .btnr      (btnr),
      .sw        (sw),
      .led       (led),
      .an        (an),
      .a2g       (a2g)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      addr  = 8'h00;
      pread = 1'b1;
      #1;
      total++;
      if (readdata !== 32'h0) $display("FAIL reset_status got=%h exp=%h", readdata, 32'h0);
      else passed++;
      pread = 1'b0;
      total++;
      if (led !== 12'h000) $display("FAIL reset_led got=%h exp=%h", led, 12'h000);
      else passed++;
      total++;
      if (an !== 8'hFE) $display("FAIL reset_an got=%h exp=%h", an, 8'hFE);
      else passed++;
      total++;
      if (a2g !== 7'b0000001) $display("FAIL reset_a2g got=%b exp=%b", a2g, 7'b0000001);
      else passed++;
   endtask

   task automatic test_switch;
      sw = 16'hA5C3;
      tick(3);
      addr  = 8'h04;
      pread = 1'b1;
      #1;
      total++;
      if (readdata !== 32'h0000A5C3) $display("FAIL switch_read got=%h exp=%h", readdata, 32'h0000A5C3);
      else passed++;
      pread = 1'b0;
      addr  = 8'h00;
   endtask

   task automatic test_btnr;
      addr = 8'h00;
      btnr = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         total++;
         if (readdata[0] !== (i == 6))
            $display("FAIL sw_rdy_edge%0d got=%b exp=%b", i, readdata[0], (i == 6));
         else passed++;
      end
      tick(4);
      btnr = 1'b0;
      tick(10);
      pread = 1'b1;
      #1;
      total++;
      if (readdata !== 32'h1) $display("FAIL status_read got=%h exp=%h", readdata, 32'h1);
      else passed++;
      tick(1);
      total++;
      if (readdata !== 32'h1) $display("FAIL status_read_no_clear got=%h exp=%h", readdata, 32'h1);
      else passed++;
      addr = 8'h04;
      #1;
      total++;
      if (readdata !== 32'h0000A5C3) $display("FAIL switch_read_flagged got=%h exp=%h", readdata, 32'h0000A5C3);
      else passed++;
      tick(1);
      pread = 1'b0;
      addr  = 8'h00;
      #1;
      total++;
      if (readdata !== 32'h0) $display("FAIL sw_rdy_cleared got=%h exp=%h", readdata, 32'h0);
      else passed++;
      btnr = 1'b1;
      tick(2);
      btnr = 1'b0;
      tick(12);
      total++;
      if (readdata !== 32'h0) $display("FAIL bounce_rejected got=%h exp=%h", readdata, 32'h0);
      else passed++;
   endtask

   task automatic test_btnl;
      addr = 8'h00;
      btnl = 1'b1;
      tick(8);
      btnl = 1'b0;
      tick(8);
      total++;
      if (readdata !== 32'h2) $display("FAIL led_rdy_set got=%h exp=%h", readdata, 32'h2);
      else passed++;
      addr      = 8'h08;
      writedata = 32'hFFFF_F123;
      pwrite    = 1'b1;
      tick(1);
      pwrite = 1'b0;
      total++;
      if (led !== 12'h123) $display("FAIL led_write got=%h exp=%h", led, 12'h123);
      else passed++;
      addr = 8'h00;
      #1;
      total++;
      if (readdata !== 32'h0) $display("FAIL led_rdy_cleared got=%h exp=%h", readdata, 32'h0);
      else passed++;
      // The press is accepted on the 6th edge after the rise; the write shares that edge.
      btnl = 1'b1;
      tick(5);
      addr      = 8'h08;
      writedata = 32'h0000_0456;
      pwrite    = 1'b1;
      tick(1);
      pwrite = 1'b0;
      total++;
      if (led !== 12'h456) $display("FAIL led_write_collide got=%h exp=%h", led, 12'h456);
      else passed++;
      addr = 8'h00;
      #1;
      total++;
      if (readdata !== 32'h2) $display("FAIL set_wins got=%h exp=%h", readdata, 32'h2);
      else passed++;
      btnl = 1'b0;
      tick(8);
   endtask

   task automatic test_display;
      logic [7:0] exp_an  [8];
      logic [6:0] exp_seg [8];
      exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      // disp = 0x01234567: digit 0 shows 7 ... digit 7 shows 0.
      exp_seg = '{7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
                  7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
      reset = 1'b1;
      tick(1);
      reset     = 1'b0;
      addr      = 8'h0C;
      writedata = 32'h0123_4567;
      pwrite    = 1'b1;
      tick(1);
      pwrite = 1'b0;
      addr   = 8'h00;
      for (int k = 1; k <= 9; k++) begin
         total++;
         if (an !== exp_an[k % 8] || a2g !== exp_seg[k % 8])
            $display("FAIL scan_step%0d got=%h/%b exp=%h/%b", k, an, a2g, exp_an[k % 8], exp_seg[k % 8]);
         else passed++;
         tick(1);
      end
   endtask

   task automatic test_reset_mid;
      addr = 8'h00;
      btnl = 1'b1;
      btnr = 1'b1;
      tick(8);
      btnl = 1'b0;
      btnr = 1'b0;
      tick(8);
      total++;
      if (readdata !== 32'h3) $display("FAIL both_flags got=%h exp=%h", readdata, 32'h3);
      else passed++;
      addr      = 8'h08;
      writedata = 32'h0000_0ABC;
      pwrite    = 1'b1;
      tick(1);
      pwrite = 1'b0;
      addr   = 8'h00;
      total++;
      if (led !== 12'hABC) $display("FAIL led_before_reset got=%h exp=%h", led, 12'hABC);
      else passed++;
      btnr = 1'b1;
      tick(3);
      reset = 1'b1;
      #1;
      total++;
      if (readdata !== 32'h0 || led !== 12'h0)
         $display("FAIL mid_reset_regs got=%h/%h exp=%h/%h", readdata, led, 32'h0, 12'h0);
      else passed++;
      total++;
      if (an !== 8'hFE || a2g !== 7'b0000001)
         $display("FAIL mid_reset_disp got=%h/%b exp=%h/%b", an, a2g, 8'hFE, 7'b0000001);
      else passed++;
      addr = 8'h04;
      #1;
      total++;
      if (readdata !== 32'h0) $display("FAIL mid_reset_sw got=%h exp=%h", readdata, 32'h0);
      else passed++;
      addr = 8'h00;
      tick(1);
      reset = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         total++;
         if (readdata[0] !== (i == 6))
            $display("FAIL post_reset_edge%0d got=%b exp=%b", i, readdata[0], (i == 6));
         else passed++;
      end
      btnr = 1'b0;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_switch();
      test_btnr();
      test_btnl();
      test_display();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
